// File: rtl/raw_capture.sv
// Raw Bayer capture front end: registers the sensor bus, gates capture to whole
// frames under start/stop control and emits the pixel stream with X/Y coordinates.
//
// state  | meaning
// IDLE   | capture disabled, waiting for iSTART
// ARMED  | waiting for the next frame-valid rising edge
// ACTIVE | inside a captured frame, forwarding line-valid pixels
module raw_capture #(
  parameter int COLUMN_WIDTH = 1280,
  parameter int ROW_HEIGHT   = 960
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [11:0] iDATA,
  input  logic        iFVAL,
  input  logic        iLVAL,
  input  logic        iSTART,
  input  logic        iEND,
  output logic [11:0] oDATA,
  output logic        oDVAL,
  output logic [15:0] oX_Cont,
  output logic [15:0] oY_Cont,
  output logic [31:0] oFrame_Cont,
  output logic        oLINE_ERR
);

  localparam logic [15:0] X_LAST = 16'(COLUMN_WIDTH - 1);
  localparam logic [15:0] Y_ROWS = 16'(ROW_HEIGHT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t      state;
  state_t      stateNext;

  logic [11:0] dataS1;
  logic        fvalS1;
  logic        lvalS1;
  logic        fvalPrev;
  logic        lvalPrev;
  logic [15:0] xCnt;
  logic [15:0] yCnt;
  logic        endReq;

  logic        fvalRise;
  logic        fvalFall;
  logic        lvalFall;
  logic        armNow;
  logic        frameStart;
  logic        frameEnd;
  logic        pixValid;
  logic        lineBreak;
  logic [15:0] xCur;
  logic [15:0] yCur;
  logic [15:0] yInc;
  logic [15:0] xNext;
  logic [15:0] yNext;

  // Edges are taken on the registered sensor strobes so they line up with dataS1.
  assign fvalRise = fvalS1 & ~fvalPrev;
  assign fvalFall = ~fvalS1 & fvalPrev;
  assign lvalFall = ~lvalS1 & lvalPrev;

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext  = state;
    armNow     = 1'b0;
    frameStart = 1'b0;
    frameEnd   = 1'b0;
    case (state)
      IDLE: begin
        if (!iEND && iSTART) begin
          stateNext = ARMED;
          armNow    = 1'b1;
        end
      end
      ARMED: begin
        if (iEND) begin
          stateNext = IDLE;
        end else if (fvalRise) begin
          stateNext  = ACTIVE;
          frameStart = 1'b1;
        end
      end
      ACTIVE: begin
        if (fvalFall) begin
          frameEnd  = 1'b1;
          stateNext = (endReq || iEND) ? IDLE : ARMED;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Coordinate update; the frame-start cycle behaves as if X/Y were already zero.
  always_comb begin
    xCur      = frameStart ? 16'd0 : xCnt;
    yCur      = frameStart ? 16'd0 : yCnt;
    yInc      = (yCur == 16'hFFFF) ? yCur : yCur + 16'd1;
    pixValid  = ((state == ACTIVE) || frameStart) && fvalS1 && lvalS1;
    lineBreak = (state == ACTIVE) && lvalFall && (xCnt != 16'd0);
    xNext     = xCur;
    yNext     = yCur;
    if (pixValid) begin
      if (xCur == X_LAST) begin
        xNext = 16'd0;
        yNext = yInc;
      end else begin
        xNext = xCur + 16'd1;
      end
    end else if (lineBreak) begin
      xNext = 16'd0;
      yNext = yInc;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      dataS1      <= '0;
      fvalS1      <= 1'b0;
      lvalS1      <= 1'b0;
      fvalPrev    <= 1'b0;
      lvalPrev    <= 1'b0;
      xCnt        <= '0;
      yCnt        <= '0;
      endReq      <= 1'b0;
      oDATA       <= '0;
      oDVAL       <= 1'b0;
      oX_Cont     <= '0;
      oY_Cont     <= '0;
      oFrame_Cont <= '0;
      oLINE_ERR   <= 1'b0;
    end else begin
      dataS1   <= iDATA;
      fvalS1   <= iFVAL;
      lvalS1   <= iLVAL;
      fvalPrev <= fvalS1;
      lvalPrev <= lvalS1;
      xCnt     <= xNext;
      yCnt     <= yNext;
      // A stop request only outlives the cycle while a frame is still in flight.
      endReq   <= (state == ACTIVE && stateNext == ACTIVE) ? (endReq | iEND) : 1'b0;
      oDVAL    <= pixValid;
      if (pixValid) begin
        oDATA   <= dataS1;
        oX_Cont <= xCur;
        oY_Cont <= yCur;
      end
      if (frameEnd) begin
        oFrame_Cont <= oFrame_Cont + 32'd1;
      end
      if (armNow) begin
        oLINE_ERR <= 1'b0;
      end else if (lineBreak || (frameEnd && yCnt != Y_ROWS)) begin
        oLINE_ERR <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_raw_capture.sv
// Directed bench for raw_capture with a 4x2 frame geometry; each scenario task
// drives its stimulus and compares the captured stream against hand-built expectations.
module tb_raw_capture;

  logic        iCLK;
  logic        iRST;
  logic [11:0] iDATA;
  logic        iFVAL;
  logic        iLVAL;
  logic        iSTART;
  logic        iEND;
  logic [11:0] oDATA;
  logic        oDVAL;
  logic [15:0] oX_Cont;
  logic [15:0] oY_Cont;
  logic [31:0] oFrame_Cont;
  logic        oLINE_ERR;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [59:0] got[$];
  logic [59:0] exp[$];

  raw_capture #(.COLUMN_WIDTH(4), .ROW_HEIGHT(2)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iFVAL(iFVAL), .iLVAL(iLVAL),
    .iSTART(iSTART), .iEND(iEND), .oDATA(oDATA), .oDVAL(oDVAL),
    .oX_Cont(oX_Cont), .oY_Cont(oY_Cont), .oFrame_Cont(oFrame_Cont),
    .oLINE_ERR(oLINE_ERR)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) cyc <= cyc + 1;

  function automatic logic [59:0] ent(input int c, input int d, input int x, input int y);
    return {16'(c), 12'(d), 16'(x), 16'(y)};
  endfunction

  always @(negedge iCLK) begin
    if (iRST && oDVAL) got.push_back(ent(cyc, int'(oDATA), int'(oX_Cont), int'(oY_Cont)));
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic pulse(input bit s, input bit e);
    iSTART = s;
    iEND   = e;
    tick();
    iSTART = 1'b0;
    iEND   = 1'b0;
    tick();
  endtask

  // Two-line frame; pixel n drives iEND when n == endAt. Pixels leave the DUT two edges after launch.
  task automatic driveFrame(input int len0, input int len1, input int d0, input bit expOn, input int endAt);
    int d;
    int n;
    int lineLen;
    d = d0;
    n = 0;
    iFVAL = 1'b1;
    tick();
    for (int ln = 0; ln < 2; ln++) begin
      lineLen = (ln == 0) ? len0 : len1;
      for (int i = 0; i < lineLen; i++) begin
        iLVAL = 1'b1;
        iDATA = 12'(d);
        iEND  = (n == endAt);
        if (expOn) exp.push_back(ent(cyc + 2, d, i, ln));
        tick();
        d++;
        n++;
      end
      iLVAL = 1'b0;
      iEND  = 1'b0;
      tick();
      tick();
    end
    iFVAL = 1'b0;
    repeat (4) tick();
  endtask

  task automatic clearQ();
    got.delete();
    exp.delete();
  endtask

  task automatic test_reset();
    iRST = 1'b0;
    repeat (3) tick();
    checks++; if (oDVAL !== 1'b0) begin failures++; $display("FAIL reset_dval got=%0b want=0", oDVAL); end
    checks++; if (oDATA !== 12'h0) begin failures++; $display("FAIL reset_data got=%h want=0", oDATA); end
    checks++; if (oX_Cont !== 16'h0 || oY_Cont !== 16'h0) begin failures++; $display("FAIL reset_xy got=%0d,%0d want=0,0", oX_Cont, oY_Cont); end
    checks++; if (oFrame_Cont !== 32'h0) begin failures++; $display("FAIL reset_frames got=%0d want=0", oFrame_Cont); end
    checks++; if (oLINE_ERR !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b want=0", oLINE_ERR); end
    iRST = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic_frame();
    clearQ();
    pulse(1'b1, 1'b0);
    driveFrame(4, 4, 1, 1'b1, -1);
    checks++; if (got.size() !== exp.size()) begin failures++; $display("FAIL basic_count got=%0d want=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL basic_pix%0d got=%h want=%h", i, got[i], exp[i]); end
    end
    checks++; if (oFrame_Cont !== 32'd1) begin failures++; $display("FAIL basic_frames got=%0d want=1", oFrame_Cont); end
    checks++; if (oLINE_ERR !== 1'b0) begin failures++; $display("FAIL basic_err got=%0b want=0", oLINE_ERR); end
  endtask

  task automatic test_mid_frame_start();
    pulse(1'b0, 1'b1);
    clearQ();
    iFVAL = 1'b1;
    tick();
    tick();
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
    for (int i = 0; i < 4; i++) begin iLVAL = 1'b1; iDATA = 12'(8'h80 + i); tick(); end
    iLVAL = 1'b0;
    tick();
    iFVAL = 1'b0;
    repeat (4) tick();
    checks++; if (got.size() !== 0) begin failures++; $display("FAIL midstart_skip got=%0d want=0", got.size()); end
    driveFrame(4, 4, 'h100, 1'b1, -1);
    checks++; if (got.size() !== exp.size()) begin failures++; $display("FAIL midstart_count got=%0d want=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL midstart_pix%0d got=%h want=%h", i, got[i], exp[i]); end
    end
    checks++; if (oFrame_Cont !== 32'd2) begin failures++; $display("FAIL midstart_frames got=%0d want=2", oFrame_Cont); end
  endtask

  task automatic test_end_request();
    clearQ();
    driveFrame(4, 4, 'h200, 1'b1, 2);
    checks++; if (got.size() !== exp.size()) begin failures++; $display("FAIL end_count got=%0d want=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL end_pix%0d got=%h want=%h", i, got[i], exp[i]); end
    end
    checks++; if (oFrame_Cont !== 32'd3) begin failures++; $display("FAIL end_frames got=%0d want=3", oFrame_Cont); end
    clearQ();
    driveFrame(4, 4, 'h240, 1'b0, -1);
    checks++; if (got.size() !== 0) begin failures++; $display("FAIL end_idle_frame got=%0d want=0", got.size()); end
    pulse(1'b1, 1'b1);
    driveFrame(4, 4, 'h260, 1'b0, -1);
    checks++; if (got.size() !== 0) begin failures++; $display("FAIL end_wins got=%0d want=0", got.size()); end
    checks++; if (oFrame_Cont !== 32'd3) begin failures++; $display("FAIL end_frames_hold got=%0d want=3", oFrame_Cont); end
  endtask

  task automatic test_short_line();
    clearQ();
    pulse(1'b1, 1'b0);
    driveFrame(3, 4, 'h010, 1'b1, -1);
    driveFrame(4, 4, 'h020, 1'b1, -1);
    checks++; if (got.size() !== exp.size()) begin failures++; $display("FAIL short_count got=%0d want=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL short_pix%0d got=%h want=%h", i, got[i], exp[i]); end
    end
    checks++; if (oLINE_ERR !== 1'b1) begin failures++; $display("FAIL short_err_sticky got=%0b want=1", oLINE_ERR); end
    checks++; if (oFrame_Cont !== 32'd5) begin failures++; $display("FAIL short_frames got=%0d want=5", oFrame_Cont); end
    pulse(1'b0, 1'b1);
    checks++; if (oLINE_ERR !== 1'b1) begin failures++; $display("FAIL short_err_idle got=%0b want=1", oLINE_ERR); end
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
    checks++; if (oLINE_ERR !== 1'b0) begin failures++; $display("FAIL short_err_clear got=%0b want=0", oLINE_ERR); end
    tick();
  endtask

  task automatic test_lval_between_frames();
    clearQ();
    for (int i = 0; i < 6; i++) begin
      iLVAL = i[0];
      iDATA = 12'(12'h0A0 + i);
      tick();
    end
    iLVAL = 1'b0;
    repeat (3) tick();
    checks++; if (got.size() !== 0 || oDVAL !== 1'b0) begin failures++; $display("FAIL gap_dval got=%0d want=0", got.size()); end
    checks++; if (oX_Cont !== 16'd3 || oY_Cont !== 16'd1) begin failures++; $display("FAIL gap_xy got=%0d,%0d want=3,1", oX_Cont, oY_Cont); end
    checks++; if (oFrame_Cont !== 32'd5) begin failures++; $display("FAIL gap_frames got=%0d want=5", oFrame_Cont); end
    driveFrame(4, 4, 'h300, 1'b1, -1);
    checks++; if (got.size() !== exp.size()) begin failures++; $display("FAIL gap_count got=%0d want=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL gap_pix%0d got=%h want=%h", i, got[i], exp[i]); end
    end
    checks++; if (oFrame_Cont !== 32'd6) begin failures++; $display("FAIL gap_frames_after got=%0d want=6", oFrame_Cont); end
  endtask

  task automatic test_reset_mid_frame();
    iFVAL = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin iLVAL = 1'b1; iDATA = 12'(12'h350 + i); tick(); end
    iRST = 1'b0;
    tick();
    iRST = 1'b1;
    checks++; if (oDVAL !== 1'b0 || oDATA !== 12'h0) begin failures++; $display("FAIL rst_mid_data got=%0b/%h want=0/0", oDVAL, oDATA); end
    checks++; if (oX_Cont !== 16'h0 || oY_Cont !== 16'h0) begin failures++; $display("FAIL rst_mid_xy got=%0d,%0d want=0,0", oX_Cont, oY_Cont); end
    checks++; if (oFrame_Cont !== 32'h0 || oLINE_ERR !== 1'b0) begin failures++; $display("FAIL rst_mid_cnt got=%0d/%0b want=0/0", oFrame_Cont, oLINE_ERR); end
    tick();
    iLVAL = 1'b0;
    tick();
    iFVAL = 1'b0;
    repeat (4) tick();
    clearQ();
    driveFrame(4, 4, 'h380, 1'b0, -1);
    checks++; if (got.size() !== 0) begin failures++; $display("FAIL rst_no_rearm got=%0d want=0", got.size()); end
    pulse(1'b1, 1'b0);
    driveFrame(4, 4, 'h400, 1'b1, -1);
    checks++; if (got.size() !== exp.size()) begin failures++; $display("FAIL rst_count got=%0d want=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL rst_pix%0d got=%h want=%h", i, got[i], exp[i]); end
    end
    checks++; if (oFrame_Cont !== 32'd1) begin failures++; $display("FAIL rst_frames got=%0d want=1", oFrame_Cont); end
  endtask

  initial begin
    iRST   = 1'b0;
    iDATA  = '0;
    iFVAL  = 1'b0;
    iLVAL  = 1'b0;
    iSTART = 1'b0;
    iEND   = 1'b0;
    test_reset();
    test_basic_frame();
    test_mid_frame_start();
    test_end_request();
    test_short_line();
    test_lval_between_frames();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
